jstk2_spi_responder: RTL and testbench
======================================

Name: jstk2_spi_responder

Overview:
- SPI mode-0 slave emulating the PmodJSTK2 joystick end of the link; it is the responder to the existing JSTK2 SPI master interfaces.
- Serves 5-byte position/button packets from parallel inputs and decodes the master's optional LED command.
- Used as a bench/board-to-board joystick stand-in, so steering can be exercised without the physical Pmod.
- Fully oversampled: SCLK/SS/MOSI are synchronised into clk; no logic is clocked by SCLK.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on SCLK, SS and MOSI (legal 2..3).
- PKT_BYTES, 5, bytes per packet with defined content; later bytes read 0x00.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master, idle low, at most clk/8.
- ss  in  1  slave select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  MISO drive enable, high while a frame is active.
- x_pos  in  10  joystick X value to report.
- y_pos  in  10  joystick Y value to report.
- btn  in  2  bit0 is the stick button, bit1 is the trigger.
- led_rgb  out  24  last accepted LED colour {R,G,B}.
- pkt_done  out  1  one-clk pulse after a frame carrying at least PKT_BYTES full bytes ends.
- frame_active  out  1  high from LOAD until return to IDLE.

Behaviour:
- Reset (rst low, asynchronous): miso=0, miso_oe=0, led_rgb=0, pkt_done=0, frame_active=0, state IDLE, counters and synchronisers cleared.
- Edge detection runs on the synchronised signals. The ss fall and sclk rise/fall events are each one clk wide.
- State machine:
  - IDLE: miso_oe=0. On ss fall, go to LOAD.
  - LOAD (1 clk):
    - Snapshot x_pos, y_pos and btn.
    - Build the packet: b0=x[7:0], b1={6'b0,x[9:8]}, b2=y[7:0], b3={6'b0,y[9:8]}, b4={6'b0,btn}.
    - Load b0 into the TX shifter. Drive miso with b0[7] and set miso_oe=1. Clear bit_cnt, byte_cnt and the RX shifter.
    - Go to SHIFT. Latency from the physical ss fall to a valid MISO is at most SYNC_STAGES+2 clk.
  - SHIFT:
    - On sclk rise: sample mosi into the RX shifter (MSB first) and increment bit_cnt.
    - On sclk fall with bit_cnt≠0: shift TX left and drive the next bit.
    - When bit_cnt wraps 7→0: the RX byte is complete, byte_cnt increments (saturating at 7), and the next TX byte is loaded on that sclk fall. Bytes with index ≥ PKT_BYTES are 0x00.
    - On ss rise: go to DONE. A partial byte in progress is discarded.
  - DONE (1 clk):
    - miso_oe=0 and miso=0.
    - pkt_done=1 only if byte_cnt ≥ PKT_BYTES.
    - Commit the LED command (see Optional Feature).
    - Go to IDLE.
- Corner cases:
  - ss rise in LOAD goes to DONE with byte_cnt=0, so there is no pulse.
  - ss fall while in DONE is honoured: DONE→IDLE→LOAD costs 2 clk, which is within the setup budget because sclk ≤ clk/8.
  - sclk edges while ss is high are ignored.
  - Input changes during a frame do not alter the packet, because the LOAD snapshot is used.
- Reset asserted mid-frame: immediate IDLE, MISO released, led_rgb cleared.

Optional Feature:
- Macro: JSTK2_LED_CMD_EN.
- Defined:
  - RX byte0 is the command byte. If it equals 0x84, RX bytes 1..3 are captured into staging registers R, G, B.
  - The staged value is copied to led_rgb in DONE only if byte_cnt ≥ 4.
  - Any other command, or a frame that is too short, leaves led_rgb unchanged.
- Undefined: no RX datapath is built, mosi is unused, and led_rgb is held at 0.

Decomposition:
- Package jstk2_pkg holds:
  - JSTK2_CMD_LED = 8'h84;
  - the packet byte index constants;
  - the state enum type {IDLE, LOAD, SHIFT, DONE};
  - the 10-bit position typedef.
- Sub-module spi_in_sync: a SYNC_STAGES-deep synchroniser with rise/fall pulse outputs, instantiated for sclk and ss (and for mosi without edge outputs).

Test Plan:
- x_pos=0x2A5, y_pos=0x1FF, btn=2'b10; 5-byte frame at 1 MHz → MISO reads A5 02 FF 01 02, pkt_done pulses once, miso_oe is low after ss rise.
- 7-byte frame → bytes 6 and 7 read 0x00; pkt_done=1.
- ss raised after 20 bits → first two bytes correct, pkt_done stays 0, next frame starts again with b0.
- JSTK2_LED_CMD_EN defined, MOSI sends 84 11 22 33 00 → led_rgb=0x112233 after DONE. Frame 84 44 (too short) → led_rgb stays 0x112233. Frame 80 … → unchanged.
- x_pos changed from 0x000 to 0x3FF mid-frame → the current frame reports 0x000, the next frame reports FF 03.
- rst driven low during byte 2 → all outputs return to reset values within 0 clk (asynchronous). After release, a full frame reads correctly.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared constants, types and packet layout for the JSTK2 SPI responder.
package jstk2_pkg;

    localparam logic [7:0] JSTK2_CMD_LED = 8'h84;

    localparam logic [2:0] PKT_X_LO = 3'd0;
    localparam logic [2:0] PKT_X_HI = 3'd1;
    localparam logic [2:0] PKT_Y_LO = 3'd2;
    localparam logic [2:0] PKT_Y_HI = 3'd3;
    localparam logic [2:0] PKT_BTN  = 3'd4;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} jstk2_state_t;

    typedef logic [9:0] jstk2_pos_t;

    function automatic logic [7:0] jstk2_pkt_byte(input logic [2:0]  idx,
                                                  input jstk2_pos_t  x,
                                                  input jstk2_pos_t  y,
                                                  input logic [1:0]  btn);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            PKT_X_LO: b = x[7:0];
            PKT_X_HI: b = {6'b0, x[9:8]};
            PKT_Y_LO: b = y[7:0];
            PKT_Y_HI: b = {6'b0, y[9:8]};
            PKT_BTN:  b = {6'b0, btn};
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// SPI link between a JSTK2 master and the joystick responder.
interface jstk2_spi_responder_if;
    logic sclk;
    logic ss;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output ss, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input ss, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/jstk2_spi_responder_sync.sv
// Multi-stage synchroniser for an asynchronous SPI pin, with one-clk edge pulses.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
endmodule

// File: rtl/jstk2_spi_responder.sv
// Oversampled SPI mode-0 slave standing in for a PmodJSTK2 joystick.
// Define JSTK2_LED_CMD_EN to build the MOSI path that decodes the LED colour command.
//
// state | meaning
// IDLE  | link quiet, MISO released, waiting for ss fall
// LOAD  | snapshot inputs, preload byte 0, drive its MSB
// SHIFT | frame in progress, bits move on synchronised sclk edges
// DONE  | frame closed, pkt_done / LED commit, back to IDLE
module jstk2_spi_responder
    import jstk2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PKT_BYTES   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    jstk2_spi_responder_if.slave   spi,
    input  logic [9:0]             x_pos,
    input  logic [9:0]             y_pos,
    input  logic [1:0]             btn,
    output logic [23:0]            led_rgb,
    output logic                   pkt_done,
    output logic                   frame_active
);
    jstk2_state_t state_q, state_d;
    logic         rearm_q;
    logic         sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic         sclk_lvl_unused, ss_lvl_unused;
    logic [2:0]   bit_cnt, byte_cnt;
    logic [7:0]   tx_q, next_byte, first_byte;
    jstk2_pos_t   x_q, y_q;
    logic [1:0]   btn_q;
    logic         miso_q, miso_oe_q;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(spi.sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(clk), .rst(rst), .d(spi.ss),
        .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall));

    // rearm_q keeps an ss fall seen in DONE alive for the IDLE that follows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rearm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rearm_q <= (state_q == DONE) && ss_fall;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall || rearm_q) state_d = LOAD;
            LOAD:    state_d = ss_rise ? DONE : SHIFT;
            SHIFT:   if (ss_rise) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign first_byte = jstk2_pkt_byte(PKT_X_LO, x_pos, y_pos, btn);
    assign next_byte  = (int'(byte_cnt) < PKT_BYTES) ? jstk2_pkt_byte(byte_cnt, x_q, y_q, btn_q) : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q       <= '0;
            y_q       <= '0;
            btn_q     <= '0;
            tx_q      <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            miso_oe_q <= (state_d == SHIFT);
            case (state_q)
                LOAD: begin
                    x_q      <= x_pos;
                    y_q      <= y_pos;
                    btn_q    <= btn;
                    tx_q     <= first_byte;
                    miso_q   <= first_byte[7];
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7 && byte_cnt != 3'd7)
                            byte_cnt <= byte_cnt + 3'd1;
                    end else if (sclk_fall) begin
                        // bit_cnt==0 on a fall means a byte just wrapped
                        if (bit_cnt != 3'd0) begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            miso_q <= tx_q[6];
                        end else begin
                            tx_q   <= next_byte;
                            miso_q <= next_byte[7];
                        end
                    end
                end
                default: ;
            endcase
            if (state_d != SHIFT)
                miso_q <= 1'b0;
        end
    end

    assign spi.miso     = miso_q;
    assign spi.miso_oe  = miso_oe_q;
    assign frame_active = (state_q != IDLE);
    assign pkt_done     = (state_q == DONE) && (int'(byte_cnt) >= PKT_BYTES);

`ifdef JSTK2_LED_CMD_EN
    logic        mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic [7:0]  rx_sh, cmd_q, rx_byte;
    logic [23:0] stage_q, led_q;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(spi.mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    assign rx_byte = {rx_sh[6:0], mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sh   <= '0;
            cmd_q   <= '0;
            stage_q <= '0;
            led_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    rx_sh <= '0;
                    cmd_q <= '0;
                end
                SHIFT: if (sclk_rise) begin
                    rx_sh <= rx_byte;
                    if (bit_cnt == 3'd7) begin
                        case (byte_cnt)
                            3'd0: cmd_q <= rx_byte;
                            3'd1: if (cmd_q == JSTK2_CMD_LED) stage_q[23:16] <= rx_byte;
                            3'd2: if (cmd_q == JSTK2_CMD_LED) stage_q[15:8]  <= rx_byte;
                            3'd3: if (cmd_q == JSTK2_CMD_LED) stage_q[7:0]   <= rx_byte;
                            default: ;
                        endcase
                    end
                end
                DONE: if (cmd_q == JSTK2_CMD_LED && byte_cnt >= 3'd4) led_q <= stage_q;
                default: ;
            endcase
        end
    end

    assign led_rgb = led_q;
`else
    logic unused_mosi;
    assign unused_mosi = spi.mosi;
    assign led_rgb     = '0;
`endif
endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Self-checking bench for jstk2_spi_responder: scripted and random SPI frames against a packet/LED model.
module tb_jstk2_spi_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x_pos = '0, y_pos = '0;
    logic [1:0]  btn = '0;
    logic [23:0] led_rgb;
    logic        pkt_done, frame_active;

    jstk2_spi_responder_if spi_bus ();

    jstk2_spi_responder dut (
        .clk(clk), .rst(rst), .spi(spi_bus.slave),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
        .led_rgb(led_rgb), .pkt_done(pkt_done), .frame_active(frame_active));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int pulses = 0;

    logic [7:0]  tx_mosi [0:7];
    logic [7:0]  rx_miso [0:7];
    logic [23:0] led_exp = '0;
    logic [9:0]  snap_x, snap_y;
    logic [1:0]  snap_btn;

    always @(negedge clk) if (pkt_done === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        case (i)
            0: return snap_x[7:0];
            1: return {6'b0, snap_x[9:8]};
            2: return snap_y[7:0];
            3: return {6'b0, snap_y[9:8]};
            4: return {6'b0, snap_btn};
            default: return 8'h00;
        endcase
    endfunction

    task automatic run_frame(input int nbits, input int half, input int rst_bit,
                             input int chg_bit, input logic [9:0] chg_x);
        int p0, full, limit;
        p0       = pulses;
        snap_x   = x_pos;
        snap_y   = y_pos;
        snap_btn = btn;
        for (int i = 0; i < 8; i++) rx_miso[i] = 8'h00;
        spi_bus.ss = 1'b0;
        repeat (10) @(negedge clk);
        chk("oe_in_frame", spi_bus.miso_oe, 1'b1);
        chk("active_in_frame", frame_active, 1'b1);
        for (int b = 0; b < nbits; b++) begin
            spi_bus.mosi = tx_mosi[b / 8][7 - (b % 8)];
            if (b == chg_bit) x_pos = chg_x;
            if (b == rst_bit) begin
                rst = 1'b0;
                #1;
                chk("rst_miso", spi_bus.miso, 1'b0);
                chk("rst_oe", spi_bus.miso_oe, 1'b0);
                chk("rst_led", led_rgb, 24'h0);
                chk("rst_done", pkt_done, 1'b0);
                chk("rst_active", frame_active, 1'b0);
                @(negedge clk);
                rst = 1'b1;
            end
            repeat (half) @(negedge clk);
            spi_bus.sclk = 1'b1;
            rx_miso[b / 8][7 - (b % 8)] = spi_bus.miso;
            repeat (half) @(negedge clk);
            spi_bus.sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_bus.ss = 1'b1;
        repeat (12) @(negedge clk);

        full  = nbits / 8;
        limit = (rst_bit >= 0) ? rst_bit / 8 : full;
        for (int i = 0; i < limit; i++) chk($sformatf("miso_byte%0d", i), rx_miso[i], exp_byte(i));
        chk("pkt_done_pulses", pulses - p0, (rst_bit < 0 && full >= 5) ? 1 : 0);
        chk("oe_after", spi_bus.miso_oe, 1'b0);
        chk("miso_after", spi_bus.miso, 1'b0);
        chk("active_after", frame_active, 1'b0);
`ifdef JSTK2_LED_CMD_EN
        if (rst_bit >= 0) led_exp = '0;
        else if (full >= 4 && tx_mosi[0] == 8'h84) led_exp = {tx_mosi[1], tx_mosi[2], tx_mosi[3]};
`endif
        chk("led_rgb", led_rgb, led_exp);
    endtask

    task automatic set_mosi(input logic [7:0] b0, b1, b2, b3, b4);
        tx_mosi[0] = b0; tx_mosi[1] = b1; tx_mosi[2] = b2; tx_mosi[3] = b3; tx_mosi[4] = b4;
        for (int i = 5; i < 8; i++) tx_mosi[i] = 8'h00;
    endtask

    initial begin
        logic [7:0] tp [0:4];
        spi_bus.ss   = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;
        set_mosi(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        #2 rst = 1'b0;
        #1;
        chk("reset_miso", spi_bus.miso, 1'b0);
        chk("reset_oe", spi_bus.miso_oe, 1'b0);
        chk("reset_led", led_rgb, 24'h0);
        chk("reset_done", pkt_done, 1'b0);
        chk("reset_active", frame_active, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        // 1 MHz reference frame
        x_pos = 10'h2A5; y_pos = 10'h1FF; btn = 2'b10;
        run_frame(40, 50, -1, -1, '0);
        tp[0] = 8'hA5; tp[1] = 8'h02; tp[2] = 8'hFF; tp[3] = 8'h01; tp[4] = 8'h02;
        for (int i = 0; i < 5; i++) chk("tp_frame_byte", rx_miso[i], tp[i]);

        run_frame(56, 10, -1, -1, '0);
        run_frame(20, 10, -1, -1, '0);
        run_frame(40, 10, -1, -1, '0);

        set_mosi(8'h84, 8'h11, 8'h22, 8'h33, 8'h00);
        run_frame(40, 10, -1, -1, '0);
        set_mosi(8'h84, 8'h44, 8'h00, 8'h00, 8'h00);
        run_frame(16, 10, -1, -1, '0);
        set_mosi(8'h80, 8'h55, 8'h66, 8'h77, 8'h00);
        run_frame(40, 10, -1, -1, '0);

        x_pos = 10'h000;
        run_frame(40, 10, -1, 12, 10'h3FF);
        run_frame(40, 10, -1, -1, '0);
        chk("tp_next_x_lo", rx_miso[0], 8'hFF);
        chk("tp_next_x_hi", rx_miso[1], 8'h03);

        set_mosi(8'h84, 8'hAB, 8'hCD, 8'hEF, 8'h00);
        run_frame(40, 10, -1, -1, '0);
        run_frame(40, 10, 20, -1, '0);
        repeat (8) @(negedge clk);
        run_frame(40, 10, -1, -1, '0);

        for (int f = 0; f < 12; f++) begin
            x_pos = 10'($urandom);
            y_pos = 10'($urandom);
            btn   = 2'($urandom);
            for (int i = 0; i < 8; i++) tx_mosi[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) tx_mosi[0] = 8'h84;
            run_frame($urandom_range(8, 56), $urandom_range(8, 12), -1, -1, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
